// File: rtl/spn_pkg.sv
// Shared types and default widths for the SPN host-side controller.
// Opcode and FSM encodings are common to the controller, its interface and benches.
package spn_pkg;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_ENC = 2'b01,
      OP_DEC = 2'b10,
      OP_RSV = 2'b11
   } spn_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP
   } host_state_t;

   localparam int SPN_DW = 16;
   localparam int SPN_KW = 32;

   // Only encrypt and decrypt ever reach the core.
   function automatic logic op_is_legal(input logic [1:0] op);
      return (op == OP_ENC) || (op == OP_DEC);
   endfunction

endpackage

// File: rtl/spn_host_ctrl_if.sv
// Request/response streams plus the core pin bundle of the SPN host controller.
// slave = controller view, master = host front-end / core environment view.
interface spn_host_ctrl_if #(
   parameter int DW = 16,
   parameter int KW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [DW-1:0] req_data;
   logic [KW-1:0] req_key;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_op;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;

   logic [1:0]    core_opcode;
   logic [DW-1:0] core_data;
   logic [KW-1:0] core_key;
   logic [DW-1:0] core_result;
   logic [1:0]    core_valid;

   modport slave (
      input  req_valid, req_op, req_data, req_key,
      output req_ready,
      output rsp_valid, rsp_op, rsp_data, rsp_err,
      input  rsp_ready,
      output core_opcode, core_data, core_key,
      input  core_result, core_valid
   );

   modport master (
      output req_valid, req_op, req_data, req_key,
      input  req_ready,
      input  rsp_valid, rsp_op, rsp_data, rsp_err,
      output rsp_ready,
      input  core_opcode, core_data, core_key,
      output core_result, core_valid
   );

endinterface

// File: rtl/spn_sat_ctr.sv
// Up-counter with increment enable that sticks at all-ones instead of wrapping.
module spn_sat_ctr #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/spn_host_ctrl.sv
// Initiator-side controller for the SPN core: accepts enc/dec requests, drives the
// core, waits for its valid echo and returns a buffered result or error response.
module spn_host_ctrl
   import spn_pkg::*;
#(
   parameter int DW      = SPN_DW,
   parameter int KW      = SPN_KW,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   spn_host_ctrl_if.slave bus,
   output logic [15:0]    cnt_done,
   output logic [15:0]    cnt_err
);

   localparam int WW = $clog2(TIMEOUT + 1);

   host_state_t   state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [WW-1:0] wait_q, wait_d;

   logic [1:0]    core_opcode_q, core_opcode_d;
   logic [DW-1:0] core_data_q, core_data_d;
   logic [KW-1:0] core_key_q, core_key_d;

   logic          rsp_valid_q, rsp_valid_d;
   logic [1:0]    rsp_op_q, rsp_op_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic          rsp_err_q, rsp_err_d;

   logic          done_inc;
   logic          err_inc;

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      wait_d        = wait_q;
      core_opcode_d = core_opcode_q;
      core_data_d   = core_data_q;
      core_key_d    = core_key_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_op_d      = rsp_op_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      done_inc      = 1'b0;
      err_inc       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_d = bus.req_op;
               if (op_is_legal(bus.req_op)) begin
                  state_d       = S_ISSUE;
                  core_opcode_d = bus.req_op;
                  core_data_d   = bus.req_data;
                  core_key_d    = bus.req_key;
                  wait_d        = WW'(1);
               end else begin
                  // Reserved/NOP requests are answered without touching the core.
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_op_d    = bus.req_op;
                  rsp_data_d  = '0;
                  rsp_err_d   = 1'b1;
                  err_inc     = 1'b1;
               end
            end
         end

         S_ISSUE: begin
            // A matching echo wins even on the final allowed wait cycle.
            if (bus.core_valid == op_q) begin
               state_d       = S_RESP;
               core_opcode_d = OP_NOP;
               rsp_valid_d   = 1'b1;
               rsp_op_d      = op_q;
               rsp_data_d    = bus.core_result;
               rsp_err_d     = 1'b0;
               done_inc      = 1'b1;
            end else if ((bus.core_valid != 2'b00) || (wait_q == WW'(TIMEOUT))) begin
               state_d       = S_RESP;
               core_opcode_d = OP_NOP;
               rsp_valid_d   = 1'b1;
               rsp_op_d      = op_q;
               rsp_data_d    = '0;
               rsp_err_d     = 1'b1;
               err_inc       = 1'b1;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end

         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         op_q          <= OP_NOP;
         wait_q        <= '0;
         core_opcode_q <= OP_NOP;
         core_data_q   <= '0;
         core_key_q    <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_op_q      <= OP_NOP;
         rsp_data_q    <= '0;
         rsp_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         wait_q        <= wait_d;
         core_opcode_q <= core_opcode_d;
         core_data_q   <= core_data_d;
         core_key_q    <= core_key_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_op_q      <= rsp_op_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   assign bus.req_ready   = (state_q == S_IDLE);
   assign bus.core_opcode = core_opcode_q;
   assign bus.core_data   = core_data_q;
   assign bus.core_key    = core_key_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_op      = rsp_op_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_err     = rsp_err_q;

   spn_sat_ctr #(.W(16)) u_cnt_done (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (done_inc),
      .cnt_o (cnt_done)
   );

   spn_sat_ctr #(.W(16)) u_cnt_err (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (err_inc),
      .cnt_o (cnt_err)
   );

endmodule

// File: tb/tb_spn_host_ctrl.sv
// Scoreboard bench for spn_host_ctrl: a behavioural core model answers after a chosen
// latency with a chosen echo; expected responses are queued at request acceptance.
module tb_spn_host_ctrl;
   import spn_pkg::*;

   localparam int DW  = 16;
   localparam int KW  = 32;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cnt_done;
   logic [15:0] cnt_err;

   spn_host_ctrl_if #(.DW(DW), .KW(KW)) bus ();

   spn_host_ctrl #(.DW(DW), .KW(KW), .TIMEOUT(TMO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .cnt_done (cnt_done),
      .cnt_err  (cnt_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] data;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] data;
      logic [31:0] key;
      int          lat;
      logic [1:0]  echo;
      logic [15:0] res;
   } core_t;

   exp_t  sb_q[$];
   core_t cfg_q[$];

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int exp_done = 0;
   int exp_err  = 0;
   int last_hs  = -100;
   int bp_cnt   = 0;
   bit rdy_rand = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural core: counts cycles of a non-NOP opcode and echoes on the chosen one.
   bit    busy     = 1'b0;
   int    busy_cnt = 0;
   int    nop_run  = 0;
   bit    had_txn  = 1'b0;
   core_t cur_c;

   always @(negedge clk) begin
      if (bus.core_opcode != 2'b00) begin
         if (!busy) begin
            busy     = 1'b1;
            busy_cnt = 0;
            if (had_txn) chk("nop_gap", 64'(nop_run >= 2), 64'd1);
            had_txn = 1'b1;
            if (cfg_q.size() == 0) begin
               chk("core_unexpected_drive", 64'(bus.core_opcode), 64'd0);
               cur_c.op = bus.core_opcode; cur_c.data = bus.core_data; cur_c.key = bus.core_key;
               cur_c.lat = -1; cur_c.echo = 2'b00; cur_c.res = 16'h0;
            end else begin
               cur_c = cfg_q.pop_front();
            end
         end
         busy_cnt++;
         nop_run = 0;
         chk("core_opcode", 64'(bus.core_opcode), 64'(cur_c.op));
         chk("core_data", 64'(bus.core_data), 64'(cur_c.data));
         chk("core_key", 64'(bus.core_key), 64'(cur_c.key));
         if (busy_cnt == cur_c.lat) begin
            bus.core_valid  = cur_c.echo;
            bus.core_result = cur_c.res;
         end else begin
            bus.core_valid  = 2'b00;
            bus.core_result = 16'($urandom);
         end
      end else begin
         busy = 1'b0;
         nop_run++;
         bus.core_valid  = 2'($urandom);
         bus.core_result = 16'($urandom);
      end
   end

   // Monitor: pops on the first cycle of each response, then checks it stays put.
   bit   held  = 1'b0;
   int   n_rsp = 0;
   exp_t cur_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         held          = 1'b0;
         bus.rsp_ready = 1'b0;
      end else if (bus.rsp_valid) begin
         chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
         chk("core_opcode_in_resp", 64'(bus.core_opcode), 64'd0);
         if (!held) begin
            held = 1'b1;
            if (sb_q.size() == 0) begin
               chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
               cur_e.op = bus.rsp_op; cur_e.data = bus.rsp_data; cur_e.err = bus.rsp_err;
               cur_e.acc = cyc - 1; cur_e.lat = 1;
            end else begin
               cur_e = sb_q.pop_front();
               if (cur_e.err) exp_err++; else exp_done++;
               n_rsp++;
               $display("rsp %0d: op=%0d data=%h err=%0d lat=%0d | exp op=%0d data=%h err=%0d lat=%0d",
                        n_rsp, bus.rsp_op, bus.rsp_data, bus.rsp_err, cyc - cur_e.acc,
                        cur_e.op, cur_e.data, cur_e.err, cur_e.lat);
               chk("rsp_latency", 64'(cyc - cur_e.acc), 64'(cur_e.lat));
            end
         end
         chk("rsp_op", 64'(bus.rsp_op), 64'(cur_e.op));
         chk("rsp_data", 64'(bus.rsp_data), 64'(cur_e.data));
         chk("rsp_err", 64'(bus.rsp_err), 64'(cur_e.err));
         chk("cnt_done", 64'(cnt_done), 64'(exp_done));
         chk("cnt_err", 64'(cnt_err), 64'(exp_err));
         if (bp_cnt > 0) begin
            bus.rsp_ready = 1'b0;
            bp_cnt--;
         end else begin
            bus.rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (bus.rsp_ready) begin
            held    = 1'b0;
            last_hs = cyc;
         end
      end else begin
         if (held) begin
            chk("rsp_dropped", 64'(held), 64'd0);
            held = 1'b0;
         end
         bus.rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic issue(input logic [1:0] op, input logic [15:0] data, input logic [31:0] key,
                        input int lat, input logic [1:0] echo, input logic [15:0] res,
                        input bit abort, output int acc);
      exp_t  e;
      core_t c;
      int    w;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = data;
      bus.req_key   = key;
      w = 0;
      while (!bus.req_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!bus.req_ready) begin
         chk("req_accept_timeout", 64'(bus.req_ready), 64'd1);
         bus.req_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc;
      if (op == OP_ENC || op == OP_DEC) begin
         c.op = op; c.data = data; c.key = key; c.lat = lat; c.echo = echo; c.res = res;
         cfg_q.push_back(c);
      end
      if (!abort) begin
         e.op  = op;
         e.acc = cyc;
         if (!(op == OP_ENC || op == OP_DEC)) begin
            e.err = 1'b1; e.data = 16'h0; e.lat = 1;
         end else if (lat > TMO) begin
            e.err = 1'b1; e.data = 16'h0; e.lat = TMO + 1;
         end else begin
            e.err  = (echo != op);
            e.data = e.err ? 16'h0 : res;
            e.lat  = lat + 1;
         end
         sb_q.push_back(e);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_op    = 2'($urandom);
      bus.req_data  = 16'($urandom);
      bus.req_key   = $urandom;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((sb_q.size() != 0 || bus.rsp_valid) && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_data  = '0;
      bus.req_key   = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_op", 64'(bus.rsp_op), 64'd0);
      chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_core_opcode", 64'(bus.core_opcode), 64'd0);
      chk("rst_core_data", 64'(bus.core_data), 64'd0);
      chk("rst_core_key", 64'(bus.core_key), 64'd0);
      chk("rst_cnt_done", 64'(cnt_done), 64'd0);
      chk("rst_cnt_err", 64'(cnt_err), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases: enc, illegal ops, timeout and its boundary, mismatch.
      issue(OP_ENC, 16'h1234, 32'hDEADBEEF, 3, OP_ENC, 16'hA5C3, 1'b0, a1);
      drain();
      issue(OP_RSV, 16'h5555, 32'h12345678, 1, OP_RSV, 16'h0, 1'b0, a1);
      drain();
      issue(OP_NOP, 16'hAAAA, 32'h0, 1, OP_ENC, 16'h0, 1'b0, a1);
      drain();
      issue(OP_ENC, 16'h0F0F, 32'hCAFEF00D, 1000, OP_ENC, 16'h1111, 1'b0, a1);
      drain();
      issue(OP_DEC, 16'h3C3C, 32'h01020304, TMO, OP_DEC, 16'hBEEF, 1'b0, a1);
      drain();
      issue(OP_ENC, 16'h7777, 32'h89ABCDEF, TMO + 1, OP_ENC, 16'h2222, 1'b0, a1);
      drain();
      issue(OP_DEC, 16'h4242, 32'h0BADCAFE, 2, OP_ENC, 16'h3333, 1'b0, a1);
      drain();
      issue(OP_ENC, 16'h0001, 32'h00000001, 1, OP_ENC, 16'h9999, 1'b0, a1);
      drain();

      // Backpressure then a back-to-back request queued behind it.
      rdy_rand = 1'b0;
      bp_cnt   = 5;
      issue(OP_ENC, 16'hC0DE, 32'hFEEDFACE, 2, OP_ENC, 16'h6789, 1'b0, a1);
      issue(OP_DEC, 16'hD00D, 32'h13579BDF, 4, OP_DEC, 16'h4321, 1'b0, a2);
      chk("b2b_accept_after_hs", 64'(a2 - last_hs), 64'd1);
      chk("b2b_drive_cycle", 64'(bus.core_opcode), 64'(OP_DEC));
      drain();
      rdy_rand = 1'b1;

      // Randomized traffic.
      for (int t = 0; t < 150; t++) begin
         logic [1:0] op, echo;
         int         lat;
         op   = 2'($urandom_range(0, 3));
         lat  = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(1, TMO + 2));
         echo = ($urandom_range(0, 3) != 0) ? op : 2'($urandom_range(1, 3));
         if (echo == 2'b00) echo = 2'b01;
         issue(op, 16'($urandom), $urandom, lat, echo, 16'($urandom), 1'b0, a1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      // Reset on the second ISSUE cycle: everything clears, no response appears.
      issue(OP_ENC, 16'hABCD, 32'h55AA55AA, 1000, OP_ENC, 16'h0, 1'b1, a1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      exp_done = 0;
      exp_err  = 0;
      chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
      chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("abort_rsp_op", 64'(bus.rsp_op), 64'd0);
      chk("abort_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("abort_core_opcode", 64'(bus.core_opcode), 64'd0);
      chk("abort_core_data", 64'(bus.core_data), 64'd0);
      chk("abort_core_key", 64'(bus.core_key), 64'd0);
      chk("abort_cnt_done", 64'(cnt_done), 64'd0);
      chk("abort_cnt_err", 64'(cnt_err), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      issue(OP_DEC, 16'h2468, 32'h11223344, 5, OP_DEC, 16'h8642, 1'b0, a1);
      drain();
      chk("core_cfg_leftover", 64'(cfg_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
